// File: rtl/seq_shift_add_mult.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one partial-product step per clock.
// Define MULT_SIGNED_EN to add two's-complement operands (sign-magnitude) selected by signed_mode.
module seq_shift_add_mult #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic               w_accept;
  logic               w_step;
  logic               w_finish;

  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_acc;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_product;

  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod_mag;
  logic [2*WIDTH-1:0] w_prod_fix;

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values, whatever the block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state and output decode.
  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (abort)                  w_next_state = ST_IDLE;
        else if (r_cnt == LAST_CNT) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        // abort is deliberately not looked at here: a start in DONE always wins.
        if (start) begin
          w_accept     = 1'b1;
          w_next_state = ST_RUN;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign w_step   = (r_state == ST_RUN) && !abort;
  assign w_finish = w_step && (r_cnt == LAST_CNT);

  // One shift-add step: the carry out of the add becomes the new top bit after the shift.
  assign w_addend   = r_mplier[0] ? r_mcand : '0;
  assign w_sum      = {1'b0, r_acc} + {1'b0, w_addend};
  assign w_prod_mag = {w_sum, r_mplier[WIDTH-1:1]};

`ifdef MULT_SIGNED_EN
  localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W = (2 * WIDTH)'(1);

  logic r_neg;
  logic w_neg;

  // abs(-2^(W-1)) = 2^(W-1) still fits in W unsigned bits, so the full range stays exact.
  assign w_a_mag    = (signed_mode && a[WIDTH-1]) ? (~a + ONE_W) : a;
  assign w_b_mag    = (signed_mode && b[WIDTH-1]) ? (~b + ONE_W) : b;
  assign w_neg      = signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
  assign w_prod_fix = r_neg ? (~w_prod_mag + ONE_2W) : w_prod_mag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_neg <= 1'b0;
    else if (w_accept) r_neg <= w_neg;
  end
`else
  logic w_unused_signed_mode;

  assign w_unused_signed_mode = signed_mode;
  assign w_a_mag    = a;
  assign w_b_mag    = b;
  assign w_prod_fix = w_prod_mag;
`endif

  // Datapath: operand capture, shift-add iteration and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_mcand  <= w_a_mag;
      r_mplier <= w_b_mag;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_step) begin
      r_acc    <= w_sum[WIDTH:1];
      r_mplier <= {w_sum[0], r_mplier[WIDTH-1:1]};
      r_cnt    <= r_cnt + CW'(1);
      if (w_finish) r_product <= w_prod_fix;
    end
  end

  assign product = r_product;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Self-checking bench for seq_shift_add_mult (WIDTH=4): directed handshake cases plus random
// operands checked against a plain-arithmetic reference product.
module tb_seq_shift_add_mult;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic           abort;
  logic           signed_mode;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int n_asserts = 0;
  int n_fail    = 0;
  logic [2*W-1:0] exp_product;

  seq_shift_add_mult #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .product     (product)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference product from plain integer arithmetic.
  function automatic logic [2*W-1:0] ref_mult(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic sm);
    int p;
`ifdef MULT_SIGNED_EN
    if (sm) p = int'($signed(x)) * int'($signed(y));
    else    p = int'(x) * int'(y);
`else
    p = int'(x) * int'(y);
`endif
    return p[2*W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction from IDLE: accept, W busy cycles, one done cycle, back to IDLE.
  task automatic do_mult(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tsm);
    logic [2*W-1:0] exp;
    exp = ref_mult(ta, tb, tsm);
    start = 1'b1; a = ta; b = tb; signed_mode = tsm;
    tick();
    start = 1'b0; a = W'($urandom); b = W'($urandom); signed_mode = 1'($urandom);
    for (int i = 0; i < W; i++) begin
      check("run_busy", busy, 1'b1);
      check("run_done", done, 1'b0);
      check("run_hold", product, exp_product);
      tick();
    end
    check("done_pulse", done, 1'b1);
    check("done_busy", busy, 1'b0);
    check($sformatf("product %0h*%0h sm=%0b", ta, tb, tsm), product, exp);
    exp_product = exp;
    tick();
    check("after_done", done, 1'b0);
    check("after_busy", busy, 1'b0);
    check("after_hold", product, exp_product);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    exp_product = '0;
    tick();
    tick();
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_product", product, '0);
    rst_n = 1'b1;
    tick();

    // Largest unsigned operands and zero operands (no early exit).
    do_mult(4'd15, 4'd15, 1'b0);
    check("max_product", exp_product, 8'hE1);
    do_mult(4'd0, 4'd9, 1'b0);
    do_mult(4'd7, 4'd0, 1'b0);

    // start pulsed during RUN is dropped: only one done.
    start = 1'b1; a = 4'd3; b = 4'd5;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; a = 4'd2; b = 4'd2;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("ignored_start_done", done, 1'b1);
    check("ignored_start_prod", product, 8'd15);
    exp_product = 8'd15;
    for (int i = 0; i < W + 2; i++) begin
      tick();
      check("no_second_done", done, 1'b0);
      check("no_second_busy", busy, 1'b0);
    end

    // Back-to-back via DONE; abort in DONE must not block the new start.
    start = 1'b1; a = 4'd6; b = 4'd7;
    tick();
    a = 4'd5; b = 4'd5;
    for (int i = 0; i < W; i++) begin
      check("b2b_first_run", done, 1'b0);
      tick();
    end
    check("b2b_first_done", done, 1'b1);
    check("b2b_first_prod", product, 8'd42);
    abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0; a = 4'd1; b = 4'd1;
    for (int i = 0; i < W; i++) begin
      check("b2b_second_busy", busy, 1'b1);
      check("b2b_second_nodone", done, 1'b0);
      check("b2b_hold", product, 8'd42);
      tick();
    end
    check("b2b_second_done", done, 1'b1);
    check("b2b_second_prod", product, 8'd25);
    exp_product = 8'd25;
    tick();
    check("b2b_idle", done, 1'b0);

    // abort in IDLE has no effect.
    abort = 1'b1;
    tick();
    tick();
    abort = 1'b0;
    check("idle_abort_busy", busy, 1'b0);
    check("idle_abort_prod", product, exp_product);

    // abort in the second RUN cycle: back to IDLE, no done, product kept.
    start = 1'b1; a = 4'd9; b = 4'd9;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_prod", product, 8'd25);
    for (int i = 0; i < W + 1; i++) begin
      tick();
      check("abort_no_done", done, 1'b0);
    end

    // Asynchronous reset in the middle of RUN.
    start = 1'b1; a = 4'd15; b = 4'd15;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_prod", product, '0);
    exp_product = '0;
    tick();
    rst_n = 1'b1;
    tick();
    do_mult(4'd11, 4'd13, 1'b0);

`ifdef MULT_SIGNED_EN
    do_mult(4'h8, 4'h8, 1'b1);
    check("signed_min_min", exp_product, 8'h40);
    do_mult(4'hD, 4'd5, 1'b1);
    check("signed_neg_pos", exp_product, 8'hF1);
    do_mult(4'd7, 4'hF, 1'b1);
    check("signed_pos_neg", exp_product, 8'hF9);
    do_mult(4'hF, 4'hF, 1'b0);
`endif

    // Random operands; signed_mode is randomised too (ignored in the unsigned build).
    for (int i = 0; i < 24; i++) begin
      do_mult(W'($urandom), W'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
